insn_fetch: RTL

- Instruction fetch unit; produces the 16-bit instruction word and its address for the decoder stage.
- Sits between instruction memory and the decoder.
- Issues pipelined in-order word reads from memory and buffers the results in a small FIFO.
- Hands instructions downstream with a valid/ready handshake.
- Handles control-flow redirects (load_ip): flushes the FIFO and discards stale in-flight responses.

---
 rtl/insn_fetch.sv | 88 ++++++++
 1 files changed

// File: rtl/insn_fetch.sv
// insn_fetch: in-order pipelined instruction fetch with a credit-limited FIFO.
// A redirect flushes the FIFO and drops every response still in flight.
module insn_fetch #(
  parameter int          DEPTH      = 2,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] insn_o,
  output logic [15:0] insn_addr_o,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_addr_i
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [15:0]   pc_q, pc_d, rpc_q, rpc_d, tgt;
  logic          req_q, req_d, gnt, pop, push;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   addr_q [DEPTH];
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign mem_req_o    = req_q & ~redirect_i;
  assign mem_addr_o   = pc_q;
  assign insn_valid_o = cnt_q != '0;
  assign insn_o       = data_q[rd_q];
  assign insn_addr_o  = addr_q[rd_q];
  // rpc_q is the address of the next response that will be kept; since grants
  // are sequential from the last redirect target it replaces an address queue.
  always_comb begin
    tgt    = {redirect_addr_i[15:1], 1'b0};
    gnt    = mem_req_o & mem_gnt_i;
    pop    = insn_valid_o & insn_ready_i;
    push   = mem_rvalid_i & (drop_q == '0) & ~redirect_i;
    out_d  = out_q + CW'(gnt) - CW'(mem_rvalid_i);
    drop_d = redirect_i ? out_d : (mem_rvalid_i && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    cnt_d  = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d   = redirect_i ? '0 : pop ? inc(rd_q) : rd_q;
    wr_d   = redirect_i ? '0 : push ? inc(wr_q) : wr_q;
    pc_d   = redirect_i ? tgt : gnt ? pc_q + 16'd2 : pc_q;
    rpc_d  = redirect_i ? tgt : push ? rpc_q + 16'd2 : rpc_q;
    req_d  = ({1'b0, out_d} + {1'b0, cnt_d}) < (CW + 1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= {RESET_ADDR[15:1], 1'b0};
      rpc_q  <= {RESET_ADDR[15:1], 1'b0};
      req_q  <= 1'b0;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      req_q  <= req_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      if (push) begin
        data_q[wr_q] <= mem_rdata_i;
        addr_q[wr_q] <= rpc_q;
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == CW'(DEPTH)));
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid_i |-> out_q != '0);
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= out_q);
endmodule
